// File: rtl/jk_pkg.sv
// Shared definitions for the JK register family.
// Contents:
//   MODE_* : operating-mode encodings for the 2-bit mode bus
//   jk_next: next state of a single JK flip-flop given its present state and J/K
package jk_pkg;

  localparam logic [1:0] MODE_JK = 2'b00;
  localparam logic [1:0] MODE_UP = 2'b01;
  localparam logic [1:0] MODE_DN = 2'b10;
  localparam logic [1:0] MODE_LD = 2'b11;

  // Classic JK truth table: hold, clear, set, toggle.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic nxt;
    case ({j, k})
      2'b00:   nxt = q;
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      2'b11:   nxt = ~q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jk_dff.sv
// One-bit edge-triggered JK flip-flop with synchronous reset and clock enable.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset, loads rst_val
//   en      : clock enable, low holds state
//   rst_val : value taken on reset
//   j, k    : JK inputs
//   q       : registered state
module jk_dff
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic rst_val,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  // State register: reset beats enable, enable gates the JK update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= rst_val;
    end else if (en) begin
      r_q <= jk_next(r_q, j, k);
    end else begin
      r_q <= r_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_universal_reg.sv
// WIDTH-bit register built from JK flip-flops with four modes:
// per-bit JK, binary up-count, binary down-count and parallel load.
// Counting drives each bit's J/K from the carry/borrow AND chain of the
// lower bits rather than from an adder.
// Parameters: WIDTH (bits), RST_VAL (reset value), WRAP (1 wrap, 0 saturate)
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (q <= RST_VAL, ovf <= 0)
//   en   : clock enable, low holds q and clears ovf
//   mode : 00 JK, 01 up, 10 down, 11 load
//   j, k : per-bit JK inputs (JK mode)
//   d    : parallel load data (load mode)
//   q    : register state
//   tc   : combinational terminal count for the current mode
//   ovf  : registered one-cycle pulse after a wrapping edge
module jk_universal_reg
  import jk_pkg::*;
#(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   RST_VAL = '0,
  parameter int                 WRAP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_carry;   // w_carry[i]  = AND of q[i-1:0]
  logic [WIDTH-1:0] w_borrow;  // w_borrow[i] = AND of ~q[i-1:0]
  logic             w_at_max;
  logic             w_at_min;
  logic             w_tc;
  logic             w_sat_hold;
  logic             w_wrap;
  logic             r_ovf;

  // Ripple AND chains; bit 0 always sees an active carry/borrow so it toggles.
  always_comb begin
    w_carry  = '0;
    w_borrow = '0;
    w_carry[0]  = 1'b1;
    w_borrow[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      w_carry[i]  = w_carry[i-1]  &  w_q[i-1];
      w_borrow[i] = w_borrow[i-1] & ~w_q[i-1];
    end
  end

  assign w_at_max = &w_q;
  assign w_at_min = ~|w_q;

  // Terminal count depends only on state and mode, never on en.
  always_comb begin
    w_tc = 1'b0;
    case (mode)
      MODE_UP: w_tc = w_at_max;
      MODE_DN: w_tc = w_at_min;
      default: w_tc = 1'b0;
    endcase
  end

  // In saturate mode a terminal count freezes the counter; otherwise it wraps.
  assign w_sat_hold = (WRAP == 0) && w_tc;
  assign w_wrap     = (WRAP != 0) && w_tc;

  // Per-bit J/K selection by mode.
  always_comb begin
    w_j = '0;
    w_k = '0;
    case (mode)
      MODE_JK: begin
        w_j = j;
        w_k = k;
      end
      MODE_UP: begin
        if (w_sat_hold) begin
          w_j = '0;
          w_k = '0;
        end else begin
          w_j = w_carry;
          w_k = w_carry;
        end
      end
      MODE_DN: begin
        if (w_sat_hold) begin
          w_j = '0;
          w_k = '0;
        end else begin
          w_j = w_borrow;
          w_k = w_borrow;
        end
      end
      MODE_LD: begin
        w_j = d;
        w_k = ~d;
      end
      default: begin
        w_j = '0;
        w_k = '0;
      end
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_dff u_bit (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .rst_val (RST_VAL[g]),
      .j       (w_j[g]),
      .k       (w_k[g]),
      .q       (w_q[g])
    );
  end

  // Overflow pulse: set by a wrapping edge, cleared on any other edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (en) begin
      r_ovf <= w_wrap;
    end else begin
      r_ovf <= 1'b0;
    end
  end

  assign q   = w_q;
  assign tc  = w_tc;
  assign ovf = r_ovf;

endmodule
